port_req_queue: RTL and testbench
=================================

# port_req_queue

Per-port request FIFO that sits directly upstream of the port steering stage: one instance per memory port buffers incoming read/write requests, stamps each with a 2-bit request tag, and presents the head entry as that port's addr/datain/wen/valid/req_tag/id bundle. The downstream memory arbitration pops the head with `out_ready`. The memory response path returns `rsp_done` pulses, which retire tags. The block never holds more than four requests, queued plus in flight, so request tags are unique per port.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, 2..4.
- `ADDR_W`, 10: address width.
- `DATA_W`, 16: write-data width.
- `PORT_ID`, 2'd0: constant driven on `out_port_id`.

Ports:
- **Clock and reset (already decided):** one clock; reset is asynchronous and active-high.
  - `clk`, input, 1: sole clock; all state updates on its rising edge.
  - `rst`, input, 1: asynchronous, active-high reset.
- **Request input:**
  - `in_valid`, input, 1: request offered.
  - `in_ready`, output, 1: request accepted this cycle when `in_valid && in_ready`.
  - `in_addr`, input, ADDR_W: request address.
  - `in_datain`, input, DATA_W: write data (don't-care for reads).
  - `in_wen`, input, 1: 1 = write, 0 = read.
- **Head-of-queue output:**
  - `out_valid`, output, 1: head entry present.
  - `out_ready`, input, 1: downstream pops the head this cycle.
  - `out_addr`, output, ADDR_W: head address.
  - `out_datain`, output, DATA_W: head write data.
  - `out_wen`, output, 1: head write enable.
  - `out_req_tag`, output, 2: head tag.
  - `out_port_id`, output, 2: equals `PORT_ID`.
- **Response and status:**
  - `rsp_done`, input, 1: one in-flight request retired.
  - `count`, output, 3: entries queued.
  - `inflight`, output, 3: popped but not retired.

## Operation
- **Storage:** circular buffer of DEPTH entries {addr, datain, wen, tag}, with write pointer `wp`, read pointer `rp` and a `count` register. Pointers wrap DEPTH-1 → 0.
- **Tag counter:** `next_tag` is 2 bits. On every accepted push, the entry stores `next_tag` and `next_tag` increments modulo 4 (3 → 0).
- **in_ready** = (`count` < DEPTH) && (`count` + `inflight` < 4).
  - It is a function of registered state only and must not depend on `out_ready` or `rsp_done` in the same cycle.
- **out_valid** = (`count` != 0).
- **Head fields:** when `count` == 0, `out_addr`, `out_datain`, `out_wen` and `out_req_tag` are driven to 0.
- **Pop:** occurs when `out_valid && out_ready`. `rp` advances and `inflight` increments. `out_ready` while empty is ignored.
- **Retire:** `rsp_done` decrements `inflight`. `rsp_done` while `inflight` == 0 is ignored, with no underflow.
- **Simultaneous events:**
  - Push and pop in the same cycle: `count` is unchanged and both pointers advance.
  - Pop and `rsp_done` in the same cycle: `inflight` is unchanged.
  - The invariant `count` + `inflight` ≤ 4 holds at all times.
- **Reset (asynchronous assert, any cycle including mid-transfer):**
  - `wp`, `rp`, `count`, `inflight` and `next_tag` go to 0.
  - All queued and in-flight requests are discarded. Storage contents need no reset.
  - The first post-reset request gets tag 0.

## Timing
- **Reset values:**
  - `in_ready` = 1.
  - `out_valid` = 0.
  - `out_addr`, `out_datain`, `out_wen`, `out_req_tag` = 0.
  - `out_port_id` = PORT_ID.
  - `count` = 0, `inflight` = 0.
- **Latency:** a request accepted at edge N appears at the head, with `out_valid` = 1, after edge N. There is no combinational bypass from `in_*` to `out_*`.
- **Throughput:** one push and one pop per cycle sustained, provided retirements keep `count` + `inflight` < 4.
- **Head stability:** the head is held stable while `out_valid && !out_ready`.
- **Order:** entries leave in FIFO order, so tags at the head are consecutive modulo 4.

## Test plan
- **Reset and single read:** release `rst`, push read addr 0x3A5 → the next cycle shows `out_valid` = 1, `out_addr` = 0x3A5, `out_wen` = 0, `out_req_tag` = 0, `count` = 1. Pop → `count` = 0, `inflight` = 1, outputs zeroed.
- **Fill and backpressure:** push 4 writes (data 0x1111..0x4444) with `out_ready` = 0 → `in_ready` falls after the 4th and a 5th `in_valid` is not accepted. Drain → data and tags 0,1,2,3 appear in order.
- **Tag-credit limit:** push 4, pop 4, no `rsp_done` → `count` = 0, `inflight` = 4, `in_ready` = 0. One `rsp_done` → `in_ready` = 1 the next cycle; the next push gets tag 0 (wrap).
- **Simultaneous events:**
  - With `count` = 2, push and pop in the same cycle → `count` stays 2.
  - Pop and `rsp_done` in the same cycle → `inflight` is unchanged.
  - `rsp_done` with `inflight` = 0 → `inflight` stays 0.
- **Reset mid-operation:** with `count` = 3 and `inflight` = 1, assert `rst` between edges → outputs return to reset values immediately. After release, the next push gets tag 0.
- **Streaming:** 100 random pushes with random `out_ready` and `rsp_done` one cycle after each pop → the output sequence matches the input sequence, with tags incrementing modulo 4 and no loss or duplication.

Source files
------------

// File: rtl/port_req_queue.sv
// Per-port request FIFO: buffers read/write requests, stamps each with a 2-bit tag,
// and limits queued plus in-flight requests to four so tags stay unique per port.
module port_req_queue #(
  parameter int          DEPTH   = 4,
  parameter int          ADDR_W  = 10,
  parameter int          DATA_W  = 16,
  parameter logic [1:0]  PORT_ID = 2'd0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_datain,
  input  logic              in_wen,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_datain,
  output logic              out_wen,
  output logic [1:0]        out_req_tag,
  output logic [1:0]        out_port_id,
  input  logic              rsp_done,
  output logic [2:0]        count,
  output logic [2:0]        inflight
);

  localparam int         PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] DEPTH_C = 3'(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] datain;
    logic              wen;
    logic [1:0]        tag;
  } entry_t;

  entry_t mem [DEPTH];

  logic [PTR_W-1:0] wp_reg, rp_reg;
  logic [2:0]       count_reg, count_next;
  logic [2:0]       inflight_reg, inflight_next;
  logic [1:0]       next_tag_reg;
  logic [3:0]       credit_used;
  logic             push, pop, retire;
  entry_t           head;

  // Tag credit: queued plus in-flight must stay below four before accepting more.
  assign credit_used = {1'b0, count_reg} + {1'b0, inflight_reg};
  assign in_ready    = (count_reg < DEPTH_C) && (credit_used < 4'd4);
  assign out_valid   = (count_reg != 3'd0);

  assign push   = in_valid && in_ready;
  assign pop    = out_valid && out_ready;
  assign retire = rsp_done && (inflight_reg != 3'd0);

  always_comb begin
    count_next = count_reg;
    if (push && !pop)
      count_next = count_reg + 3'd1;
    else if (pop && !push)
      count_next = count_reg - 3'd1;

    inflight_next = inflight_reg;
    if (pop && !retire)
      inflight_next = inflight_reg + 3'd1;
    else if (retire && !pop)
      inflight_next = inflight_reg - 3'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_reg       <= '0;
      rp_reg       <= '0;
      count_reg    <= 3'd0;
      inflight_reg <= 3'd0;
      next_tag_reg <= 2'd0;
    end else begin
      if (push) begin
        wp_reg       <= wp_reg + PTR_W'(1);
        next_tag_reg <= next_tag_reg + 2'd1;
      end
      if (pop)
        rp_reg <= rp_reg + PTR_W'(1);
      count_reg    <= count_next;
      inflight_reg <= inflight_next;
    end
  end

  // Storage is not reset; the count register alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push)
      mem[wp_reg] <= '{addr: in_addr, datain: in_datain, wen: in_wen, tag: next_tag_reg};
  end

  assign head = mem[rp_reg];

  always_comb begin
    out_addr    = '0;
    out_datain  = '0;
    out_wen     = 1'b0;
    out_req_tag = 2'd0;
    if (out_valid) begin
      out_addr    = head.addr;
      out_datain  = head.datain;
      out_wen     = head.wen;
      out_req_tag = head.tag;
    end
  end

  assign out_port_id = PORT_ID;
  assign count       = count_reg;
  assign inflight    = inflight_reg;

endmodule

// File: tb/tb_port_req_queue.sv
// Directed and streaming checks for port_req_queue: reset, fill, tag credit,
// simultaneous events, asynchronous reset mid-operation and random streaming.
module tb_port_req_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_wen;
  logic [9:0]  in_addr;
  logic [15:0] in_datain;
  logic        out_valid, out_ready, out_wen;
  logic [9:0]  out_addr;
  logic [15:0] out_datain;
  logic [1:0]  out_req_tag, out_port_id;
  logic        rsp_done;
  logic [2:0]  count, inflight;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  port_req_queue #(.DEPTH(4), .ADDR_W(10), .DATA_W(16), .PORT_ID(2'd2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_datain(in_datain), .in_wen(in_wen),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_datain(out_datain), .out_wen(out_wen), .out_req_tag(out_req_tag),
    .out_port_id(out_port_id),
    .rsp_done(rsp_done), .count(count), .inflight(inflight)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end else
      $display("ok   %s: %0h", name, got);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [9:0] a, input logic [15:0] d, input logic w);
    in_valid = 1'b1; in_addr = a; in_datain = d; in_wen = w;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_idle(input string pfx);
    chk({pfx, "_in_ready"},  32'(in_ready), 32'd1);
    chk({pfx, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({pfx, "_out_addr"},  32'(out_addr), 32'd0);
    chk({pfx, "_out_data"},  32'(out_datain), 32'd0);
    chk({pfx, "_out_wen"},   32'(out_wen), 32'd0);
    chk({pfx, "_out_tag"},   32'(out_req_tag), 32'd0);
    chk({pfx, "_port_id"},   32'(out_port_id), 32'd2);
    chk({pfx, "_count"},     32'(count), 32'd0);
    chk({pfx, "_inflight"},  32'(inflight), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic [9:0]  addr;
    logic [15:0] data;
    logic        wen;
    logic [1:0]  tag;
  } exp_t;

  exp_t q[$];

  initial begin
    int   m_inflight, pushes_left, pops_seen, cycles;
    logic m_tag, pop_prev;
    logic [1:0] m_tag2;
    logic m_push, m_pop, m_retire, m_ready;
    exp_t e;

    rst = 1'b1; in_valid = 0; in_addr = '0; in_datain = '0; in_wen = 0;
    out_ready = 0; rsp_done = 0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 1'b0;

    // Single read
    push1(10'h3A5, 16'h0, 1'b0);
    chk("rd_valid", 32'(out_valid), 32'd1);
    chk("rd_addr",  32'(out_addr), 32'h3A5);
    chk("rd_wen",   32'(out_wen), 32'd0);
    chk("rd_tag",   32'(out_req_tag), 32'd0);
    chk("rd_count", 32'(count), 32'd1);
    out_ready = 1; tick(); out_ready = 0;
    chk("rd_pop_count",    32'(count), 32'd0);
    chk("rd_pop_inflight", 32'(inflight), 32'd1);
    chk("rd_pop_valid",    32'(out_valid), 32'd0);
    chk("rd_pop_addr",     32'(out_addr), 32'd0);

    // Fill, backpressure, then drain into the tag-credit limit
    do_reset();
    for (int k = 0; k < 4; k++) begin
      push1(10'(k + 1), 16'(16'h1111 * (k + 1)), 1'b1);
      chk($sformatf("fill_count%0d", k), 32'(count), 32'(k + 1));
    end
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    push1(10'h3FF, 16'h5555, 1'b1);
    chk("fill_5th_count", 32'(count), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain_data%0d", k), 32'(out_datain), 32'(16'h1111 * (k + 1)));
      chk($sformatf("drain_tag%0d", k),  32'(out_req_tag), 32'(k));
      out_ready = 1; tick(); out_ready = 0;
    end
    chk("credit_count",    32'(count), 32'd0);
    chk("credit_inflight", 32'(inflight), 32'd4);
    chk("credit_in_ready", 32'(in_ready), 32'd0);
    rsp_done = 1; tick(); rsp_done = 0;
    chk("credit_ret_inflight", 32'(inflight), 32'd3);
    chk("credit_ret_in_ready", 32'(in_ready), 32'd1);
    push1(10'h2AA, 16'h0, 1'b0);
    chk("credit_wrap_tag", 32'(out_req_tag), 32'd0);

    // Simultaneous events
    rsp_done = 1; repeat (3) tick(); rsp_done = 0;
    chk("sim_inflight0", 32'(inflight), 32'd0);
    rsp_done = 1; tick(); rsp_done = 0;
    chk("sim_underflow", 32'(inflight), 32'd0);
    push1(10'h011, 16'hABCD, 1'b1);
    chk("sim_count2", 32'(count), 32'd2);
    in_valid = 1; in_addr = 10'h022; in_datain = 16'h1234; in_wen = 0; out_ready = 1;
    tick();
    in_valid = 0; out_ready = 0;
    chk("sim_pushpop_count", 32'(count), 32'd2);
    chk("sim_pushpop_tag",   32'(out_req_tag), 32'd1);
    chk("sim_pushpop_data",  32'(out_datain), 32'hABCD);
    out_ready = 1; rsp_done = 1; tick(); out_ready = 0; rsp_done = 0;
    chk("sim_poprsp_inflight", 32'(inflight), 32'd1);
    chk("sim_poprsp_count",    32'(count), 32'd1);

    // Asynchronous reset mid-operation
    push1(10'h033, 16'h0, 1'b0);
    push1(10'h044, 16'h0, 1'b0);
    chk("mid_count3",    32'(count), 32'd3);
    chk("mid_inflight1", 32'(inflight), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_idle("midrst");
    @(posedge clk); #1; rst = 1'b0;
    push1(10'h155, 16'h0, 1'b0);
    chk("midrst_tag",  32'(out_req_tag), 32'd0);
    chk("midrst_addr", 32'(out_addr), 32'h155);

    // Random streaming against a scoreboard
    do_reset();
    q.delete();
    m_inflight = 0; m_tag2 = 2'd0; pushes_left = 100; pops_seen = 0; pop_prev = 0;
    cycles = 0; m_tag = 0;
    while ((pushes_left > 0 || q.size() > 0 || m_inflight > 0) && cycles < 3000) begin
      cycles++;
      m_ready = (q.size() < 4) && (q.size() + m_inflight < 4);
      if (in_ready !== m_ready) chk("str_in_ready", 32'(in_ready), 32'(m_ready));
      if (out_valid !== (q.size() != 0)) chk("str_out_valid", 32'(out_valid), 32'(q.size() != 0));
      in_valid  = (pushes_left > 0) && ($urandom_range(0, 3) != 0);
      in_addr   = 10'($urandom);
      in_datain = 16'($urandom);
      in_wen    = 1'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      rsp_done  = pop_prev;
      m_push    = in_valid && m_ready;
      m_pop     = (q.size() != 0) && out_ready;
      m_retire  = rsp_done && (m_inflight != 0);
      if (m_pop) begin
        e = q.pop_front();
        chk($sformatf("str_addr%0d", pops_seen), 32'(out_addr), 32'(e.addr));
        chk($sformatf("str_data%0d", pops_seen), 32'(out_datain), 32'(e.data));
        chk($sformatf("str_wen%0d", pops_seen),  32'(out_wen), 32'(e.wen));
        chk($sformatf("str_tag%0d", pops_seen),  32'(out_req_tag), 32'(e.tag));
        pops_seen++;
      end
      if (m_push) begin
        q.push_back('{addr: in_addr, data: in_datain, wen: in_wen, tag: m_tag2});
        m_tag2 = m_tag2 + 2'd1;
        pushes_left--;
      end
      m_inflight = m_inflight + (m_pop ? 1 : 0) - (m_retire ? 1 : 0);
      pop_prev = m_pop;
      tick();
      in_valid = 0; out_ready = 0; rsp_done = 0;
    end
    chk("str_pops",     32'(pops_seen), 32'd100);
    chk("str_count",    32'(count), 32'd0);
    chk("str_inflight", 32'(inflight), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
